// File: rtl/instr_loader.sv
// Boot-time instruction loader: receives a length-prefixed, XOR-checksummed
// program over a byte stream (typically a UART receiver) and writes it word by
// word into instruction memory starting at BASE_ADDR.
//
// Stream layout: 4-byte little-endian word count N, then N little-endian
// 32-bit words, then one checksum byte equal to the XOR of all payload bytes.
module instr_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t      state_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] word_idx_q;
    logic [31:0] len_q;
    logic [31:0] asm_q;
    logic [31:0] asm_d;
    logic [7:0]  csum_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        done_q;
    logic        err_q;

    logic        active;
    logic        accept;
    logic        last_word;

    // Ready depends only on state and reset, never on rx_valid, so the
    // receiver side cannot form a combinational loop through us.
    assign active    = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign rx_ready  = active && !rst;
    assign busy      = active && !rst;
    assign accept    = rx_valid && rx_ready;
    assign last_word = (word_idx_q == (len_q - 32'd1));

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign err        = err_q;

    // Drop the incoming byte into the lane selected by the byte counter.
    always_comb begin
        asm_d = asm_q;
        asm_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
    end

    // Loader FSM with its datapath; the write strobe is a registered one-cycle
    // pulse issued the cycle after a word's last byte, and reset cancels it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LEN;
            byte_cnt_q <= 2'd0;
            word_idx_q <= 32'd0;
            len_q      <= 32'd0;
            asm_q      <= 32'd0;
            csum_q     <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (accept) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                asm_q      <= asm_d;
                unique case (state_q)
                    LEN: begin
                        if (byte_cnt_q == 2'd3) begin
                            len_q <= asm_d;
                            if (asm_d > MAX_WORDS) begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end else if (asm_d == 32'd0) begin
                                state_q <= CSUM;
                            end else begin
                                state_q <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        csum_q <= csum_q ^ rx_data;
                        if (byte_cnt_q == 2'd3) begin
                            we_q       <= 1'b1;
                            addr_q     <= BASE_ADDR + {word_idx_q[29:0], 2'b00};
                            wdata_q    <= asm_d;
                            word_idx_q <= word_idx_q + 32'd1;
                            if (last_word) begin
                                state_q <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (rx_data == csum_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader. One DUT instance with BASE_ADDR=0x100
// and MAX_WORDS=4 so address offsetting and the length limit are both visible.
module tb_instr_loader;

    localparam logic [31:0] TB_BASE = 32'h0000_0100;
    localparam int unsigned TB_MAX  = 4;

    logic        clk;
    logic        rst;
    logic        rxValid;
    logic [7:0]  rxData;
    logic        rxReady;
    logic        imemWe;
    logic [31:0] imemAddr;
    logic [31:0] imemWdata;
    logic        busy;
    logic        done;
    logic        err;

    int passCount;
    int checkCount;
    int cycleNum;

    logic [31:0] wrAddr[$];
    logic [31:0] wrData[$];
    int          wrCycle[$];
    logic [7:0]  stream[$];

    instr_loader #(
        .BASE_ADDR(TB_BASE),
        .MAX_WORDS(TB_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rxValid),
        .rx_data   (rxData),
        .rx_ready  (rxReady),
        .imem_we   (imemWe),
        .imem_addr (imemAddr),
        .imem_wdata(imemWdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to timestamp memory writes.
    always @(posedge clk) begin
        cycleNum <= cycleNum + 1;
    end

    // Record every write strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (imemWe === 1'b1) begin
            wrAddr.push_back(imemAddr);
            wrData.push_back(imemWdata);
            wrCycle.push_back(cycleNum);
        end
    end

    task automatic clearWrites();
        wrAddr.delete();
        wrData.delete();
        wrCycle.delete();
    endtask

    task automatic doReset();
        rst     = 1'b1;
        rxValid = 1'b0;
        rxData  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clearWrites();
    endtask

    task automatic idleCycles(input int n);
        rxValid = 1'b0;
        rxData  = 8'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until the handshake completes (bounded).
    task automatic sendByte(input logic [7:0] b);
        int waited;
        waited  = 0;
        rxValid = 1'b1;
        rxData  = b;
        @(negedge clk);
        while (rxReady !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (rxReady !== 1'b1) begin
            checkCount++;
            $display("[TB] FAIL handshake: byte %h not accepted, rx_ready=%b required 1", b, rxReady);
            rxValid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rxValid = 1'b0;
        end
    endtask

    task automatic sendStream(input int maxGap);
        foreach (stream[i]) begin
            if (maxGap > 0) idleCycles($urandom_range(0, maxGap));
            sendByte(stream[i]);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        rxValid = 1'b1;
        rxData  = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        checkCount++;
        if (rxReady !== 1'b0) $display("[TB] FAIL reset_ready: got %b required 0", rxReady);
        else passCount++;
        checkCount++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b required 0", busy);
        else passCount++;
        checkCount++;
        if (imemWe !== 1'b0) $display("[TB] FAIL reset_we: got %b required 0", imemWe);
        else passCount++;
        checkCount++;
        if (imemAddr !== TB_BASE) $display("[TB] FAIL reset_addr: got %h required %h", imemAddr, TB_BASE);
        else passCount++;
        checkCount++;
        if (imemWdata !== 32'h0) $display("[TB] FAIL reset_wdata: got %h required 0", imemWdata);
        else passCount++;
        checkCount++;
        if (done !== 1'b0 || err !== 1'b0) $display("[TB] FAIL reset_flags: done=%b err=%b required 0/0", done, err);
        else passCount++;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        rxValid = 1'b0;
        @(negedge clk);
        checkCount++;
        if (busy !== 1'b1 || rxReady !== 1'b1) $display("[TB] FAIL post_reset_busy: busy=%b ready=%b required 1/1", busy, rxReady);
        else passCount++;
        clearWrites();
    endtask

    // Payload bytes 13 05 10 00 93 05 20 00 XOR to 0xB0.
    task automatic test_two_word();
        doReset();
        stream = '{8'h02, 8'h00, 8'h00, 8'h00,
                   8'h13, 8'h05, 8'h10, 8'h00,
                   8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        sendStream(0);
        @(negedge clk);
        checkCount++;
        if (wrAddr.size() != 2) $display("[TB] FAIL two_word_count: got %0d required 2", wrAddr.size());
        else passCount++;
        if (wrAddr.size() == 2) begin
            checkCount++;
            if (wrAddr[0] !== 32'h100 || wrData[0] !== 32'h00100513)
                $display("[TB] FAIL two_word_w0: got %h@%h required 00100513@00000100", wrData[0], wrAddr[0]);
            else passCount++;
            checkCount++;
            if (wrAddr[1] !== 32'h104 || wrData[1] !== 32'h00200593)
                $display("[TB] FAIL two_word_w1: got %h@%h required 00200593@00000104", wrData[1], wrAddr[1]);
            else passCount++;
            checkCount++;
            if (wrCycle[1] - wrCycle[0] != 4)
                $display("[TB] FAIL two_word_spacing: got %0d cycles required 4", wrCycle[1] - wrCycle[0]);
            else passCount++;
        end
        checkCount++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL two_word_flags: done=%b err=%b busy=%b required 1/0/0", done, err, busy);
        else passCount++;
    endtask

    task automatic test_bad_checksum();
        bit sawReady;
        doReset();
        stream = '{8'h02, 8'h00, 8'h00, 8'h00,
                   8'h13, 8'h05, 8'h10, 8'h00,
                   8'h93, 8'h05, 8'h20, 8'h00, 8'h09};
        sendStream(0);
        @(negedge clk);
        checkCount++;
        if (wrAddr.size() != 2) $display("[TB] FAIL bad_csum_writes: got %0d required 2", wrAddr.size());
        else passCount++;
        checkCount++;
        if (err !== 1'b1 || done !== 1'b0 || rxReady !== 1'b0)
            $display("[TB] FAIL bad_csum_flags: err=%b done=%b ready=%b required 1/0/0", err, done, rxReady);
        else passCount++;
        // Bytes offered after the error must be ignored.
        sawReady = 1'b0;
        rxValid  = 1'b1;
        rxData   = 8'h5A;
        repeat (5) begin
            @(negedge clk);
            if (rxReady !== 1'b0) sawReady = 1'b1;
        end
        rxValid = 1'b0;
        @(negedge clk);
        checkCount++;
        if (sawReady || wrAddr.size() != 2 || err !== 1'b1)
            $display("[TB] FAIL err_sticky: readySeen=%b writes=%0d err=%b required 0/2/1", sawReady, wrAddr.size(), err);
        else passCount++;
    endtask

    task automatic test_zero_length();
        doReset();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendStream(0);
        @(negedge clk);
        checkCount++;
        if (wrAddr.size() != 0 || done !== 1'b1 || err !== 1'b0)
            $display("[TB] FAIL zero_len_ok: writes=%0d done=%b err=%b required 0/1/0", wrAddr.size(), done, err);
        else passCount++;
        doReset();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        sendStream(0);
        @(negedge clk);
        checkCount++;
        if (wrAddr.size() != 0 || done !== 1'b0 || err !== 1'b1)
            $display("[TB] FAIL zero_len_bad: writes=%0d done=%b err=%b required 0/0/1", wrAddr.size(), done, err);
        else passCount++;
    endtask

    task automatic test_over_limit();
        bit sawReady;
        doReset();
        stream = '{8'h04, 8'h00, 8'h00, 8'h00};
        sendStream(0);
        @(negedge clk);
        checkCount++;
        if (err !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL len_at_limit: err=%b busy=%b required 0/1", err, busy);
        else passCount++;
        doReset();
        stream = '{8'h05, 8'h00, 8'h00, 8'h00};
        sendStream(0);
        @(negedge clk);
        checkCount++;
        if (err !== 1'b1 || done !== 1'b0 || rxReady !== 1'b0)
            $display("[TB] FAIL len_over_limit: err=%b done=%b ready=%b required 1/0/0", err, done, rxReady);
        else passCount++;
        sawReady = 1'b0;
        rxValid  = 1'b1;
        rxData   = 8'h11;
        repeat (6) begin
            @(negedge clk);
            if (rxReady !== 1'b0) sawReady = 1'b1;
        end
        rxValid = 1'b0;
        checkCount++;
        if (sawReady || wrAddr.size() != 0)
            $display("[TB] FAIL over_limit_ignore: readySeen=%b writes=%0d required 0/0", sawReady, wrAddr.size());
        else passCount++;
    endtask

    // 1-word program 0x12345678; payload XOR = 78^56^34^12 = 0x08.
    task automatic test_back_to_back();
        doReset();
        stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        sendStream(0);
        // Checksum byte follows immediately, offered during the write cycle.
        rxValid = 1'b1;
        rxData  = 8'h08;
        @(negedge clk);
        checkCount++;
        if (imemWe !== 1'b1 || imemAddr !== 32'h100 || imemWdata !== 32'h12345678)
            $display("[TB] FAIL b2b_write: we=%b %h@%h required 1 12345678@00000100", imemWe, imemWdata, imemAddr);
        else passCount++;
        checkCount++;
        if (rxReady !== 1'b1) $display("[TB] FAIL b2b_ready_in_write: got %b required 1", rxReady);
        else passCount++;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
        @(negedge clk);
        checkCount++;
        if (imemWe !== 1'b0) $display("[TB] FAIL b2b_pulse_width: we=%b required 0", imemWe);
        else passCount++;
        checkCount++;
        if (done !== 1'b1 || err !== 1'b0 || wrAddr.size() != 1)
            $display("[TB] FAIL b2b_done: done=%b err=%b writes=%0d required 1/0/1", done, err, wrAddr.size());
        else passCount++;
    endtask

    task automatic test_gaps();
        doReset();
        stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        sendStream(4);
        idleCycles(3);
        @(negedge clk);
        checkCount++;
        if (wrAddr.size() != 1) $display("[TB] FAIL gaps_count: got %0d required 1", wrAddr.size());
        else passCount++;
        if (wrAddr.size() == 1) begin
            checkCount++;
            if (wrAddr[0] !== 32'h100 || wrData[0] !== 32'h12345678)
                $display("[TB] FAIL gaps_write: got %h@%h required 12345678@00000100", wrData[0], wrAddr[0]);
            else passCount++;
        end
        checkCount++;
        if (done !== 1'b1 || err !== 1'b0) $display("[TB] FAIL gaps_done: done=%b err=%b required 1/0", done, err);
        else passCount++;
    endtask

    // Restarted word 0xDEADBEEF; payload XOR = EF^BE^AD^DE = 0x22.
    task automatic test_reset_mid_word();
        doReset();
        stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE};
        sendStream(0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkCount++;
        if (imemWe !== 1'b0 || wrAddr.size() != 0 || busy !== 1'b1)
            $display("[TB] FAIL mid_reset_cancel: we=%b writes=%0d busy=%b required 0/0/1", imemWe, wrAddr.size(), busy);
        else passCount++;
        stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        sendStream(2);
        @(negedge clk);
        checkCount++;
        if (wrAddr.size() != 1) $display("[TB] FAIL restart_count: got %0d required 1", wrAddr.size());
        else passCount++;
        if (wrAddr.size() == 1) begin
            checkCount++;
            if (wrAddr[0] !== 32'h100 || wrData[0] !== 32'hDEADBEEF)
                $display("[TB] FAIL restart_write: got %h@%h required DEADBEEF@00000100", wrData[0], wrAddr[0]);
            else passCount++;
        end
        checkCount++;
        if (done !== 1'b1 || err !== 1'b0) $display("[TB] FAIL restart_done: done=%b err=%b required 1/0", done, err);
        else passCount++;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        cycleNum   = 0;
        rst        = 1'b1;
        rxValid    = 1'b0;
        rxData     = 8'h00;
        #1;
        test_reset();
        test_two_word();
        test_bad_checksum();
        test_zero_length();
        test_over_limit();
        test_back_to_back();
        test_gaps();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
